// File: rtl/mul_arb_ctrl.sv
// Shared 8x8 signed/unsigned multiplier: arbiter + 3-stage pipe (capture, Booth rows + wallace_tree, CPA), 3-cycle latency.
// All stages stall together while rsp_valid_o && !rsp_ready_i; MUL_ARB_RR_EN selects round-robin over fixed priority.

module wallace_tree #(
    parameter int DW = 16,
    parameter int PP = 5
) (
    input  logic [PP*DW-1:0] pp_i,
    output logic [DW-1:0]    sum_o,
    output logic [DW-1:0]    carry_o
);
    logic [DW-1:0] s, c, x, cy;

    // Chain of 3:2 compressors; carries are pre-shifted so the final add is sum_o + carry_o.
    always_comb begin
        s  = pp_i[DW-1:0];
        c  = pp_i[2*DW-1:DW];
        x  = '0;
        cy = '0;
        for (int i = 2; i < PP; i++) begin
            x  = pp_i[i*DW +: DW];
            cy = (s & c) | (s & x) | (c & x);
            s  = s ^ c ^ x;
            c  = {cy[DW-2:0], 1'b0};
        end
        sum_o   = s;
        carry_o = c;
    end
endmodule

module mul_arb_ctrl #(
    parameter int DW   = 8,
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*DW-1:0]   req_a_i,
    input  logic [NREQ*DW-1:0]   req_b_i,
    input  logic [NREQ-1:0]      req_signed_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [2*DW-1:0]      rsp_prod_o
);
    localparam int PW  = 2 * DW;
    localparam int NPP = 5;

    logic            adv;
    logic            gnt_any;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [DW-1:0]   sel_a, sel_b;
    logic            sel_sgn;
    int              base;
    int              idx;

    assign adv = !rsp_valid_o || rsp_ready_i;

`ifdef MUL_ARB_RR_EN
    logic [IDW-1:0] ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= IDW'(NREQ - 1);
        end else if (gnt_any) begin
            ptr <= gnt_id;
        end
    end

    assign base = int'(ptr) + 1;
`else
    assign base = 0;
`endif

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_sgn = 1'b0;
        idx     = 0;
        if (adv && !rst_i) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (base + k) % NREQ;
                if (!gnt_any && req_valid_i[idx]) begin
                    gnt_any  = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_id   = IDW'(idx);
                    sel_a    = req_a_i[idx*DW +: DW];
                    sel_b    = req_b_i[idx*DW +: DW];
                    sel_sgn  = req_signed_i[idx];
                end
            end
        end
    end

    assign req_ready_o = gnt;

    logic           a_vld, a_sgn;
    logic [DW-1:0]  a_opa, a_opb;
    logic [IDW-1:0] a_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_vld <= 1'b0;
            a_sgn <= 1'b0;
            a_opa <= '0;
            a_opb <= '0;
            a_id  <= '0;
        end else if (adv) begin
            a_vld <= gnt_any;
            if (gnt_any) begin
                a_sgn <= sel_sgn;
                a_opa <= sel_a;
                a_opb <= sel_b;
                a_id  <= gnt_id;
            end
        end
    end

    // Radix-4 Booth: b extended to 10 bits (sign or zero) gives exactly 5 digits in {-2..2}.
    logic [PW-1:0]     a_ext, mag, row;
    logic [DW+2:0]     b_ext;
    logic [2:0]        trip;
    logic              b_hi;
    logic [NPP*PW-1:0] pp;

    always_comb begin
        b_hi  = a_sgn & a_opb[DW-1];
        a_ext = a_sgn ? {{DW{a_opa[DW-1]}}, a_opa} : {{DW{1'b0}}, a_opa};
        b_ext = {b_hi, b_hi, a_opb, 1'b0};
        pp    = '0;
        trip  = '0;
        mag   = '0;
        row   = '0;
        for (int i = 0; i < NPP; i++) begin
            trip = b_ext[2*i +: 3];
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = a_ext;
                3'b011, 3'b100:                 mag = a_ext << 1;
                default:                        mag = '0;
            endcase
            row = trip[2] ? (~mag + PW'(1)) : mag;
            pp[i*PW +: PW] = row << (2 * i);
        end
    end

    logic [PW-1:0] tree_sum, tree_carry;

    wallace_tree #(.DW(PW), .PP(NPP)) u_tree (
        .pp_i    (pp),
        .sum_o   (tree_sum),
        .carry_o (tree_carry)
    );

    logic           b_vld;
    logic [PW-1:0]  b_sum, b_carry;
    logic [IDW-1:0] b_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_vld   <= 1'b0;
            b_sum   <= '0;
            b_carry <= '0;
            b_id    <= '0;
        end else if (adv) begin
            b_vld   <= a_vld;
            b_sum   <= tree_sum;
            b_carry <= tree_carry;
            b_id    <= a_id;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_prod_o  <= '0;
            rsp_id_o    <= '0;
        end else if (adv) begin
            rsp_valid_o <= b_vld;
            rsp_prod_o  <= b_sum + b_carry;
            rsp_id_o    <= b_id;
        end
    end
endmodule
